// File: rtl/johnson_code_monitor.sv
// Receive-side monitor for a start/stop Johnson counter: decodes each sample,
// checks hold/+1 ordering, counts full-cycle wraps and reports lock status.
module johnson_code_monitor #(
    parameter int WIDTH  = 4,
    parameter int RELOCK = 2,
    parameter int WRAP_W = 8
) (
    input  logic                         Clk_In,
    input  logic                         tb_Reset_In,
    input  logic                         Enable_In,
    input  logic                         Code_Valid_In,
    input  logic [WIDTH-1:0]             Code_In,
    input  logic                         Clear_Wraps_In,
    output logic [$clog2(2*WIDTH)-1:0]   Index_Out,
    output logic                         Index_Valid_Out,
    output logic                         Locked_Out,
    output logic                         Illegal_Code_Out,
    output logic                         Seq_Error_Out,
    output logic [WRAP_W-1:0]            Wrap_Count_Out
);

    localparam int IDX_W = $clog2(2 * WIDTH);
    localparam int CNT_W = $clog2(RELOCK + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               idx_vld_q, idx_vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               seq_err_q, seq_err_d;
    logic [WRAP_W-1:0]  wrap_q, wrap_d;

    logic               code_legal;
    logic [IDX_W-1:0]   code_idx;
    logic [IDX_W-1:0]   idx_next;
    logic               in_seq;
    logic               sample;
    logic               wrap_hit;

    // Low-aligned runs of ones decode to 0..W-1, high-aligned runs to W..2W-1.
    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int k = 1; k <= WIDTH; k++) begin
            if (Code_In == WIDTH'((1 << k) - 1)) begin
                code_legal = 1'b1;
                code_idx   = IDX_W'(k - 1);
            end
            if (Code_In == WIDTH'(~((1 << k) - 1))) begin
                code_legal = 1'b1;
                code_idx   = IDX_W'(WIDTH - 1 + k);
            end
        end
    end

    always_comb begin
        idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        in_seq   = idx_vld_q && ((code_idx == idx_q) || (code_idx == idx_next));
        sample   = Enable_In && Code_Valid_In;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        idx_vld_d = idx_vld_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        seq_err_d = 1'b0;
        wrap_hit  = 1'b0;
        if (sample) begin
            if (!code_legal) begin
                illegal_d = 1'b1;
                cnt_d     = '0;
                if (state_q != ACQUIRE) begin
                    state_d   = FAULT;
                    idx_vld_d = 1'b0;
                end
            end else begin
                idx_d     = code_idx;
                idx_vld_d = 1'b1;
                unique case (state_q)
                    ACQUIRE: begin
                        state_d = TRACK;
                        cnt_d   = '0;
                    end
                    TRACK: begin
                        if (in_seq) begin
                            wrap_hit = (idx_q == LAST_IDX) && (code_idx == '0);
                        end else begin
                            seq_err_d = 1'b1;
                            state_d   = FAULT;
                            cnt_d     = '0;
                        end
                    end
                    FAULT: begin
                        // The first legal sample after an illegal one only seeds idx.
                        if (!in_seq) begin
                            cnt_d = '0;
                        end else if (cnt_q >= CNT_W'(RELOCK - 1)) begin
                            state_d = TRACK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        wrap_d = wrap_q;
        if (Clear_Wraps_In) begin
            wrap_d = wrap_hit ? WRAP_W'(1) : '0;
        end else if (wrap_hit && (wrap_q != {WRAP_W{1'b1}})) begin
            wrap_d = wrap_q + 1'b1;
        end
    end

    always_ff @(posedge Clk_In or posedge tb_Reset_In) begin
        if (tb_Reset_In) begin
            state_q   <= ACQUIRE;
            idx_q     <= '0;
            idx_vld_q <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            wrap_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            idx_vld_q <= idx_vld_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
            wrap_q    <= wrap_d;
        end
    end

    assign Index_Out        = idx_q;
    assign Index_Valid_Out  = idx_vld_q;
    assign Locked_Out       = (state_q == TRACK);
    assign Illegal_Code_Out = illegal_q;
    assign Seq_Error_Out    = seq_err_q;
    assign Wrap_Count_Out   = wrap_q;

endmodule

// File: tb/tb_johnson_code_monitor.sv
// Directed plus randomized bench for johnson_code_monitor against a
// table-driven reference model of the counter sequence and lock rules.
module tb_johnson_code_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic       vld;
    logic [3:0] code;
    logic       clr;
    logic [2:0] idx_o;
    logic       idx_vld_o;
    logic       locked_o;
    logic       ill_o;
    logic       seq_o;
    logic [7:0] wrap_o;

    int tests;
    int failed;

    localparam int M_ACQ = 0;
    localparam int M_TRK = 1;
    localparam int M_FLT = 2;
    localparam int RELOCK = 2;

    logic [3:0] jtab [8];
    int m_mode;
    int m_idx;
    bit m_vld;
    int m_rel;
    bit m_ill;
    bit m_seq;
    int m_wraps;

    johnson_code_monitor dut (
        .Clk_In           (clk),
        .tb_Reset_In      (rst),
        .Enable_In        (en),
        .Code_Valid_In    (vld),
        .Code_In          (code),
        .Clear_Wraps_In   (clr),
        .Index_Out        (idx_o),
        .Index_Valid_Out  (idx_vld_o),
        .Locked_Out       (locked_o),
        .Illegal_Code_Out (ill_o),
        .Seq_Error_Out    (seq_o),
        .Wrap_Count_Out   (wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legal codes in counter order, built by running the counter itself.
    task automatic build_table();
        logic [3:0] c;
        c = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            jtab[i] = c;
            c = {c[2:0], ~c[3]};
        end
    endtask

    function automatic int decode(input logic [3:0] c);
        for (int i = 0; i < 8; i++) begin
            if (jtab[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode  = M_ACQ;
        m_idx   = 0;
        m_vld   = 0;
        m_rel   = 0;
        m_ill   = 0;
        m_seq   = 0;
        m_wraps = 0;
    endtask

    task automatic model_step(input bit e, input bit v,
                              input logic [3:0] c, input bit cl);
        int di;
        bit inseq;
        bit wrap;
        di    = decode(c);
        wrap  = 0;
        m_ill = 0;
        m_seq = 0;
        if (e && v) begin
            if (di < 0) begin
                m_ill = 1;
                m_rel = 0;
                if (m_mode != M_ACQ) begin
                    m_mode = M_FLT;
                    m_vld  = 0;
                end
            end else begin
                inseq = m_vld && (di == m_idx || di == (m_idx + 1) % 8);
                if (m_mode == M_ACQ) begin
                    m_mode = M_TRK;
                    m_rel  = 0;
                end else if (m_mode == M_TRK) begin
                    if (inseq) begin
                        wrap = (m_idx == 7) && (di == 0);
                    end else begin
                        m_seq  = 1;
                        m_mode = M_FLT;
                        m_rel  = 0;
                    end
                end else begin
                    if (inseq) begin
                        m_rel++;
                        if (m_rel >= RELOCK) begin
                            m_mode = M_TRK;
                            m_rel  = 0;
                        end
                    end else begin
                        m_rel = 0;
                    end
                end
                m_idx = di;
                m_vld = 1;
            end
        end
        if (cl) m_wraps = wrap ? 1 : 0;
        else if (wrap && m_wraps < 255) m_wraps++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_idx"}, 32'(idx_o), 32'(m_idx));
        chk({tag, "_vld"}, 32'(idx_vld_o), 32'(m_vld));
        chk({tag, "_lock"}, 32'(locked_o), 32'(m_mode == M_TRK));
        chk({tag, "_ill"}, 32'(ill_o), 32'(m_ill));
        chk({tag, "_seq"}, 32'(seq_o), 32'(m_seq));
        chk({tag, "_wrap"}, 32'(wrap_o), 32'(m_wraps));
    endtask

    task automatic step(input string tag, input bit e, input bit v,
                        input logic [3:0] c, input bit cl);
        en   = e;
        vld  = v;
        code = c;
        clr  = cl;
        @(posedge clk);
        model_step(e, v, c, cl);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] rc;
        int src;
        int r;
        tests  = 0;
        failed = 0;
        build_table();
        model_reset();
        rst  = 1'b1;
        en   = 1'b0;
        vld  = 1'b0;
        code = 4'b0000;
        clr  = 1'b0;
        #12;
        check_all("reset");
        rst = 1'b0;

        // Acquire on the counter reset code.
        step("t1", 1, 1, 4'b0001, 0);
        chk("t1_locked", 32'(locked_o), 32'd1);
        chk("t1_index", 32'(idx_o), 32'd0);

        // One full cycle, then enough cycles to saturate the wrap counter.
        for (int i = 1; i <= 8; i++) step("t2_walk", 1, 1, jtab[i % 8], 0);
        chk("t2_one_wrap", 32'(wrap_o), 32'd1);
        for (int n = 0; n < 255; n++) begin
            for (int i = 1; i <= 8; i++) step("t2_sat", 1, 1, jtab[i % 8], 0);
        end
        chk("t2_saturated", 32'(wrap_o), 32'hFF);

        // Skip from index 2 to 5, then relock after two in-order samples.
        step("t3", 1, 1, 4'b0011, 0);
        step("t3", 1, 1, 4'b0111, 0);
        step("t3_skip", 1, 1, 4'b1100, 0);
        chk("t3_seq_pulse", 32'(seq_o), 32'd1);
        chk("t3_skip_idx", 32'(idx_o), 32'd5);
        step("t3_r1", 1, 1, 4'b1000, 0);
        chk("t3_not_yet", 32'(locked_o), 32'd0);
        step("t3_r2", 1, 1, 4'b0000, 0);
        chk("t3_relocked", 32'(locked_o), 32'd1);

        // Illegal code, then invalid samples freeze everything.
        step("t4_ill", 1, 1, 4'b0101, 0);
        chk("t4_ill_pulse", 32'(ill_o), 32'd1);
        chk("t4_idx_held", 32'(idx_o), 32'd7);
        for (int i = 0; i < 3; i++) step("t4_frz", 1, 0, 4'(i * 5), 0);

        // Reseed and relock, then exercise enable gating and clears.
        step("t5_seed", 1, 1, 4'b0000, 0);
        step("t5", 1, 1, 4'b0001, 0);
        step("t5", 1, 1, 4'b0011, 0);
        for (int i = 0; i < 3; i++) step("t5_dis", 0, 1, 4'(3 * i + 4), 0);
        for (int i = 2; i < 8; i++) step("t5_walk", 1, 1, jtab[i], 0);
        step("t5_clrwrap", 1, 1, 4'b0001, 1);
        chk("t5_clr_with_wrap", 32'(wrap_o), 32'd1);
        step("t5_clr_dis", 0, 1, 4'b1011, 1);
        chk("t5_clr_disabled", 32'(wrap_o), 32'd0);

        // Random traffic: mostly in-order with holds, jumps, glitches and gaps.
        src = 1;
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                src = (src + 1) % 8;
                rc  = jtab[src];
            end else if (r < 80) begin
                rc = jtab[src];
            end else if (r < 88) begin
                src = int'($urandom_range(0, 7));
                rc  = jtab[src];
            end else begin
                rc = 4'($urandom);
            end
            step("rnd", $urandom_range(0, 19) != 0, $urandom_range(0, 19) != 0,
                 rc, $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset lands between clock edges.
        for (int i = 0; i < 4; i++) step("t6_lock", 1, 1, 4'b0001, 0);
        chk("t6_locked", 32'(locked_o), 32'd1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t6_async");
        @(posedge clk);
        #1;
        check_all("t6_held");
        rst = 1'b0;
        step("t6_reacq", 1, 1, 4'b0111, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
